ratio_div: RTL and testbench

RATIO_DIV -- requirements
Module: ratio_div

---
 rtl/ratio_div.sv | 167 ++++++++++++++++
 tb/tb_ratio_div.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ratio_div.sv
// ratio_div: sequential restoring divider computing tan = y / x for Q16.16
// operands, producing a saturated sign-magnitude Q16.16 quotient.
//
// Optional build macro RATIO_DIV_ROUND_EN: computes one extra quotient bit
// and rounds half-up on it. This adds one cycle of latency.
//
// Handshake: a request is accepted on any rising edge where start is high
// and the FSM is IDLE (busy low). The module captures y/x on that edge and
// ignores start until it returns to IDLE. Each accepted request produces
// exactly one tan_valid pulse, unless a reset aborts it. The module holds
// tan/ovf between pulses.
module ratio_div #(
   parameter int FRAC = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] y,
   input  logic [31:0] x,
   output logic        busy,
   output logic        tan_valid,
   output logic [31:0] tan,
   output logic        ovf,
   output logic [1:0]  state_dbg
);

   localparam int DW  = 32 + FRAC;
`ifdef RATIO_DIV_ROUND_EN
   localparam int NIT = DW + 1;
`else
   localparam int NIT = DW;
`endif
   localparam int CW  = $clog2(NIT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [CW-1:0]   cnt;
   logic [DW-1:0]   dvd;
   logic [32:0]     rem;
   logic [31:0]     div;
   logic [NIT-1:0]  quot;
   logic            sgn;
   logic            x_zero;
   logic            y_zero;

   logic [31:0]     mag_y;
   logic [31:0]     mag_x;
   logic [33:0]     rem_sh;
   logic            fits;
   logic            last_iter;

   logic [NIT-1:0]  q_fin;
   logic            sat;
   logic [30:0]     mag_res;
   logic            ovf_res;
   logic [31:0]     tan_res;

   assign busy      = (state != IDLE);
   assign state_dbg = state;

   // Operand magnitudes; 0x8000_0000 maps to 2^31 as an unsigned value.
   always_comb begin
      mag_y = y[31] ? (~y + 32'd1) : y;
      mag_x = x[31] ? (~x + 32'd1) : x;
   end

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      rem_sh    = {rem, dvd[DW-1]};
      fits      = (rem_sh >= {2'b00, div});
      last_iter = (cnt == CW'(NIT - 1));
   end

   // Final quotient, optional rounding, saturation and divide-by-zero handling.
   always_comb begin
`ifdef RATIO_DIV_ROUND_EN
      q_fin = {1'b0, quot[NIT-1:1]} + NIT'(quot[0]);
`else
      q_fin = quot;
`endif
      sat     = |q_fin[NIT-1:31];
      mag_res = q_fin[30:0];
      ovf_res = sat;
      if (x_zero) begin
         ovf_res = ~y_zero;
         mag_res = y_zero ? 31'd0 : 31'h7FFF_FFFF;
      end else if (sat) begin
         mag_res = 31'h7FFF_FFFF;
      end
      // A zero magnitude never carries a negative sign.
      tan_res = {sgn & (mag_res != 31'd0), mag_res};
   end

   // State register; reset wins over any start sampled on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (last_iter) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: capture in IDLE, iterate in CALC, publish the result in DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt       <= '0;
         dvd       <= '0;
         rem       <= '0;
         div       <= '0;
         quot      <= '0;
         sgn       <= 1'b0;
         x_zero    <= 1'b0;
         y_zero    <= 1'b0;
         tan       <= '0;
         ovf       <= 1'b0;
         tan_valid <= 1'b0;
      end else begin
         tan_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dvd    <= {mag_y, {FRAC{1'b0}}};
                  div    <= mag_x;
                  rem    <= '0;
                  quot   <= '0;
                  cnt    <= '0;
                  sgn    <= y[31] ^ x[31];
                  x_zero <= (x == 32'd0);
                  y_zero <= (y == 32'd0);
               end
            end
            CALC: begin
               dvd  <= {dvd[DW-2:0], 1'b0};
               rem  <= fits ? 33'(rem_sh - {2'b00, div}) : rem_sh[32:0];
               quot <= {quot[NIT-2:0], fits};
               cnt  <= cnt + CW'(1);
            end
            DONE: begin
               tan       <= tan_res;
               ovf       <= ovf_res;
               tan_valid <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ratio_div.sv
// tb_ratio_div: directed vector table, multi-cycle corner sequences and
// randomized operands checked against an arithmetic reference model.
module tb_ratio_div;

   localparam int FRAC = 16;
`ifdef RATIO_DIV_ROUND_EN
   localparam int LAT = 50;
`else
   localparam int LAT = 49;
`endif
   localparam int PERIOD = LAT + 1;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] y;
   logic [31:0] x;
   logic        busy;
   logic        tan_valid;
   logic [31:0] tan;
   logic        ovf;
   logic [1:0]  state_dbg;

   int n_checks;
   int n_errors;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] y;
      logic [31:0] x;
      logic [31:0] tan;
      logic        ovf;
   } vec_t;

   vec_t vecs[14];

   ratio_div #(.FRAC(FRAC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .y         (y),
      .x         (x),
      .busy      (busy),
      .tan_valid (tan_valid),
      .tan       (tan),
      .ovf       (ovf),
      .state_dbg (state_dbg)
   );

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: plain integer division of magnitudes, then format rules.
   function automatic logic [32:0] ref_div(input logic [31:0] yv, input logic [31:0] xv);
      longint unsigned my, mx, q;
      logic            s, o;
      logic [30:0]     m;
      my = yv[31] ? (64'h1_0000_0000 - longint'(yv)) : longint'(yv);
      mx = xv[31] ? (64'h1_0000_0000 - longint'(xv)) : longint'(xv);
      s  = yv[31] ^ xv[31];
      o  = 1'b0;
      if (mx == 0) begin
         if (my == 0) m = 31'd0;
         else begin
            m = 31'h7FFF_FFFF;
            o = 1'b1;
         end
      end else begin
`ifdef RATIO_DIV_ROUND_EN
         q = (my << (FRAC + 1)) / mx;
         q = (q >> 1) + (q & 64'd1);
`else
         q = (my << FRAC) / mx;
`endif
         if (q > 64'h7FFF_FFFF) begin
            m = 31'h7FFF_FFFF;
            o = 1'b1;
         end else begin
            m = q[30:0];
         end
      end
      if (m == 31'd0) s = 1'b0;
      return {o, s, m};
   endfunction

   // One division. mode 0: plain, 1: stray start at N+10, 2: reset at N+20.
   task automatic run_div(input string name, input logic [31:0] yv, input logic [31:0] xv,
                          input logic [31:0] exp_tan, input logic exp_ovf, input int mode);
      int          pulses;
      int          pulse_k;
      logic [31:0] got_tan;
      logic        got_ovf;
      pulses  = 0;
      pulse_k = -1;
      got_tan = '0;
      got_ovf = 1'b0;
      exp_q.delete();
      @(negedge clk);
      y     = yv;
      x     = xv;
      start = 1'b1;
      exp_q.push_back(exp_tan);
      @(posedge clk);
      for (int k = 0; k <= LAT + 3; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start = 1'b0;
            y     = $urandom;
            x     = $urandom;
         end
         if (mode == 1 && k == 9) begin
            start = 1'b1;
            y     = 32'h1234_5678;
            x     = 32'h0000_0003;
         end
         if (mode == 1 && k == 10) start = 1'b0;
         if (mode == 2 && k == 19) begin
            rst_n = 1'b0;
            start = 1'b1;
         end
         if (mode == 2 && k == 20) begin
            check({name, "_rst_busy"}, 32'(busy), 32'd0);
            check({name, "_rst_tan"}, tan, 32'd0);
            check({name, "_rst_ovf"}, 32'(ovf), 32'd0);
            rst_n = 1'b1;
            start = 1'b0;
         end
         if (mode == 2 && k == 21) check({name, "_rst_start_ignored"}, 32'(busy), 32'd0);
         if (mode != 2 && k == 1) check({name, "_busy_early"}, 32'(busy), 32'd1);
         if (mode != 2 && k == LAT - 1) check({name, "_busy_done"}, 32'(busy), 32'd1);
         if (mode != 2 && k == LAT) check({name, "_busy_after"}, 32'(busy), 32'd0);
         if (tan_valid) begin
            pulses++;
            pulse_k = k;
            got_tan = tan;
            got_ovf = ovf;
            if (exp_q.size() > 0) check({name, "_tan"}, got_tan, exp_q.pop_front());
         end
      end
      if (mode == 2) begin
         check({name, "_pulses"}, 32'(pulses), 32'd0);
      end else begin
         check({name, "_pulses"}, 32'(pulses), 32'd1);
         check({name, "_latency"}, 32'(pulse_k), 32'(LAT));
         check({name, "_ovf"}, 32'(got_ovf), 32'(exp_ovf));
         check({name, "_tan_hold"}, tan, exp_tan);
         check({name, "_ovf_hold"}, 32'(ovf), 32'(exp_ovf));
      end
      exp_q.delete();
   endtask

   initial begin
      logic [32:0] r;
      logic [31:0] ry, rx;
      int          ks[$];
      n_checks = 0;
      n_errors = 0;

      vecs[0]  = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0};
      vecs[1]  = '{32'hFFFF_0000, 32'h0001_0000, 32'h8001_0000, 1'b0};
      vecs[2]  = '{32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0};
`ifdef RATIO_DIV_ROUND_EN
      vecs[3]  = '{32'h0002_0000, 32'h0003_0000, 32'h0000_AAAB, 1'b0};
      vecs[10] = '{32'hFFFF_FFFF, 32'h0002_0000, 32'h8000_0001, 1'b0};
`else
      vecs[3]  = '{32'h0002_0000, 32'h0003_0000, 32'h0000_AAAA, 1'b0};
      vecs[10] = '{32'hFFFF_FFFF, 32'h0002_0000, 32'h0000_0000, 1'b0};
`endif
      vecs[4]  = '{32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
      vecs[5]  = '{32'h8005_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
      vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 32'h0001_0000, 1'b0};
      vecs[8]  = '{32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000, 1'b0};
      vecs[9]  = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0};
      vecs[11] = '{32'h0000_8000, 32'h0001_0000, 32'h0000_8000, 1'b0};
      vecs[12] = '{32'h7FFF_FFFF, 32'h0001_0000, 32'h7FFF_FFFF, 1'b0};
      vecs[13] = '{32'h4000_0000, 32'h0000_8000, 32'h7FFF_FFFF, 1'b1};

      // Reset block.
      rst_n = 1'b0;
      start = 1'b1;
      y     = 32'h0001_0000;
      x     = 32'h0001_0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_valid", 32'(tan_valid), 32'd0);
      check("reset_tan", tan, 32'd0);
      check("reset_ovf", 32'(ovf), 32'd0);
      check("reset_state", 32'(state_dbg), 32'd0);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed vector table.
      for (int i = 0; i < 14; i++) begin
         run_div($sformatf("vec%0d", i), vecs[i].y, vecs[i].x, vecs[i].tan, vecs[i].ovf, 0);
      end

      // Stray start while busy must not disturb the in-flight division.
      run_div("ignore_start", vecs[3].y, vecs[3].x, vecs[3].tan, vecs[3].ovf, 1);

      // Make tan non-zero, then abort a division with reset.
      run_div("pre_reset", vecs[2].y, vecs[2].x, vecs[2].tan, vecs[2].ovf, 0);
      run_div("abort", vecs[1].y, vecs[1].x, vecs[1].tan, vecs[1].ovf, 2);
      run_div("post_reset", vecs[0].y, vecs[0].x, vecs[0].tan, vecs[0].ovf, 0);

      // Streaming: start held high gives one result per PERIOD cycles.
      r = ref_div(32'h0005_0000, 32'hFFFE_0000);
      @(negedge clk);
      y     = 32'h0005_0000;
      x     = 32'hFFFE_0000;
      start = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= LAT + PERIOD + 3; k++) begin
         @(negedge clk);
         if (tan_valid) begin
            ks.push_back(k);
            check("stream_tan", tan, r[31:0]);
         end
      end
      start = 1'b0;
      repeat (LAT + 5) @(negedge clk);
      check("stream_count", 32'(ks.size()), 32'd2);
      if (ks.size() >= 2) begin
         check("stream_first", 32'(ks[0]), 32'(LAT));
         check("stream_period", 32'(ks[1] - ks[0]), 32'(PERIOD));
      end

      // Randomized operands against the reference model.
      for (int i = 0; i < 30; i++) begin
         ry = $urandom;
         if ($urandom_range(0, 3) == 0) ry = ry >> $urandom_range(1, 24);
         case ($urandom_range(0, 3))
            0: rx = $urandom;
            1: rx = $urandom_range(1, 65535);
            2: rx = ry >> $urandom_range(0, 20);
            default: rx = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
         endcase
         if ($urandom_range(0, 1) == 1) rx = ~rx + 32'd1;
         r = ref_div(ry, rx);
         run_div($sformatf("rand%0d", i), ry, rx, r[31:0], r[32], 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
